// File: rtl/jtcop_obj_dma.sv
// Object RAM to object buffer DMA for the 68000 bus: requests the bus, copies
// 2**AW words one at a time, then releases the bus and pulses done.
module jtcop_obj_dma #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          obj_copy,
  output logic          br_n,
  input  logic          bg_n,
  output logic          bgack_n,
  output logic          src_cs,
  output logic [AW-1:0] src_addr,
  input  logic [15:0]   src_dout,
  input  logic          src_ok,
  output logic          dst_we,
  output logic [AW-1:0] dst_addr,
  output logic [15:0]   dst_din,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {IDLE, REQ, RD, WR, DONE} state_t;

  localparam logic [AW-1:0] LAST = '1;

  state_t        r_state;
  logic          r_obj_copy_l;
  logic          r_pend;
  logic          r_first;
  logic [AW-1:0] r_cnt;
  logic [15:0]   r_data;
  logic          r_br_n;
  logic          r_bgack_n;
  logic          r_src_cs;
  logic          r_dst_we;
  logic          r_done;
  logic          w_rise;

  assign w_rise   = obj_copy & ~r_obj_copy_l;
  assign br_n     = r_br_n;
  assign bgack_n  = r_bgack_n;
  assign src_cs   = r_src_cs;
  assign src_addr = r_cnt;
  assign dst_we   = r_dst_we;
  assign dst_addr = r_cnt;
  assign dst_din  = r_data;
  assign busy     = (r_state != IDLE);
  assign done     = r_done;

  // A new edge wins over the IDLE clear so a request arriving on that edge is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_obj_copy_l <= 1'b0;
      r_pend       <= 1'b0;
    end else begin
      r_obj_copy_l <= obj_copy;
      if (w_rise)
        r_pend <= 1'b1;
      else if (r_state == IDLE && r_pend)
        r_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_data    <= '0;
      r_first   <= 1'b0;
      r_br_n    <= 1'b1;
      r_bgack_n <= 1'b1;
      r_src_cs  <= 1'b0;
      r_dst_we  <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_pend) begin
            r_cnt   <= '0;
            r_br_n  <= 1'b0;
            r_state <= REQ;
          end
        end
        REQ: begin
          if (!bg_n) begin
            r_br_n    <= 1'b1;
            r_bgack_n <= 1'b0;
            r_src_cs  <= 1'b1;
            r_first   <= 1'b1;
            r_state   <= RD;
          end
        end
        // The first RD cycle may still see ok from the previous access, so skip it.
        RD: begin
          r_first <= 1'b0;
          if (!r_first && src_ok) begin
            r_data   <= src_dout;
            r_src_cs <= 1'b0;
            r_dst_we <= 1'b1;
            r_state  <= WR;
          end
        end
        WR: begin
          r_dst_we <= 1'b0;
          r_cnt    <= r_cnt + AW'(1);
          if (r_cnt == LAST) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_src_cs <= 1'b1;
            r_first  <= 1'b1;
            r_state  <= RD;
          end
        end
        DONE: begin
          r_done    <= 1'b0;
          r_bgack_n <= 1'b1;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtcop_obj_dma.sv
// Bench for jtcop_obj_dma: behavioural source RAM and bus arbiter models, with
// every write logged and compared against the source contents in address order.
module tb_jtcop_obj_dma;
  localparam int AW    = 3;
  localparam int WORDS = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          objCopy;
  logic          brN;
  logic          bgN;
  logic          bgackN;
  logic          srcCs;
  logic [AW-1:0] srcAddr;
  logic [15:0]   srcDout;
  logic          srcOk;
  logic          dstWe;
  logic [AW-1:0] dstAddr;
  logic [15:0]   dstDin;
  logic          busy;
  logic          done;

  int checks = 0;
  int passed = 0;

  logic [15:0] srcMem[WORDS];
  int          lat[WORDS];
  bit          staleOn   = 1'b0;
  bit          holdGrant = 1'b0;
  bit          dropGrant = 1'b0;
  int          grantDelay = 2;
  int          rdCnt = 0;
  int          reqCnt = 0;
  int          cyc = 0;
  int          wrAddr[$];
  logic [15:0] wrData[$];
  int          wrCyc[$];
  int          doneCount = 0;
  int          invViol = 0;
  bit          prevWe = 1'b0;

  jtcop_obj_dma #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .obj_copy(objCopy), .br_n(brN), .bg_n(bgN),
    .bgack_n(bgackN), .src_cs(srcCs), .src_addr(srcAddr), .src_dout(srcDout),
    .src_ok(srcOk), .dst_we(dstWe), .dst_addr(dstAddr), .dst_din(dstDin),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Source RAM: stale ok in the first strobe cycle, then ok after lat[] extra cycles.
  always @(negedge clk) begin
    if (srcCs) begin
      if (rdCnt == 0) begin
        srcOk = staleOn; srcDout = 16'hDEAD;
      end else if (rdCnt - 1 >= lat[srcAddr]) begin
        srcOk = 1'b1; srcDout = srcMem[srcAddr];
      end else begin
        srcOk = 1'b0; srcDout = 16'hBAD0;
      end
      rdCnt++;
    end else begin
      rdCnt = 0; srcOk = staleOn; srcDout = 16'hDEAD;
    end
  end

  // Bus arbiter: grants grantDelay clocks after br_n falls, may drop bg_n while acknowledged.
  always @(negedge clk) begin
    if (holdGrant) begin
      bgN = 1'b1; reqCnt = 0;
    end else if (!brN) begin
      reqCnt++;
      if (reqCnt >= grantDelay) bgN = 1'b0;
    end else if (!bgackN) begin
      reqCnt = 0; bgN = dropGrant;
    end else begin
      reqCnt = 0; bgN = 1'b1;
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (dstWe) begin
        wrAddr.push_back(int'(dstAddr)); wrData.push_back(dstDin); wrCyc.push_back(cyc);
      end
      if (done) doneCount++;
    end
    if (!brN && !bgackN) invViol++;
    if (dstWe && prevWe) invViol++;
    prevWe = dstWe;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(negedge clk); #1;
  endtask

  task automatic clearLog;
    wrAddr.delete(); wrData.delete(); wrCyc.delete();
    doneCount = 0; invViol = 0;
  endtask

  task automatic fillSource(input int maxLat);
    for (int i = 0; i < WORDS; i++) begin
      srcMem[i] = 16'($urandom);
      if (srcMem[i] == 16'hDEAD || srcMem[i] == 16'hBAD0) srcMem[i] = 16'h1234 + 16'(i);
      lat[i] = int'($urandom_range(maxLat, 0));
    end
  endtask

  task automatic pulseCopy;
    tick; objCopy = 1'b1;
    tick; objCopy = 1'b0;
  endtask

  task automatic waitDone(input int target, input int budget, output bit timedOut);
    timedOut = 1'b1;
    for (int i = 0; i < budget; i++) begin
      tick;
      if (doneCount >= target) begin
        timedOut = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b1; objCopy = 1'b0; bgN = 1'b1;
    fillSource(0);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (brN !== 1'b1) $display("[TB] FAIL reset_br_n got %b want 1", brN); else passed++;
    checks++; if (bgackN !== 1'b1) $display("[TB] FAIL reset_bgack_n got %b want 1", bgackN); else passed++;
    checks++; if ({srcCs, dstWe, busy, done} !== 4'b0000)
      $display("[TB] FAIL reset_strobes got %b want 0000", {srcCs, dstWe, busy, done}); else passed++;
    checks++; if (srcAddr !== '0 || dstDin !== 16'h0)
      $display("[TB] FAIL reset_addr_data got %0d/%h want 0/0000", srcAddr, dstDin); else passed++;
    repeat (3) tick;
    rst_n = 1'b1;
    repeat (3) tick;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_idle_busy got %b want 0", busy); else passed++;
  endtask

  task automatic test_basic;
    bit to;
    staleOn = 1'b0; dropGrant = 1'b0; grantDelay = 2;
    fillSource(0); clearLog();
    pulseCopy();
    waitDone(1, 200, to);
    repeat (3) tick;
    checks++; if (to) $display("[TB] FAIL basic_timeout got timeout want done"); else passed++;
    checks++; if (wrAddr.size() !== WORDS)
      $display("[TB] FAIL basic_count got %0d want %0d", wrAddr.size(), WORDS); else passed++;
    for (int k = 0; k < wrAddr.size() && k < WORDS; k++) begin
      checks++;
      if (wrAddr[k] !== k || wrData[k] !== srcMem[k])
        $display("[TB] FAIL basic_word%0d got %0d:%h want %0d:%h", k, wrAddr[k], wrData[k], k, srcMem[k]);
      else passed++;
    end
    if (wrCyc.size() == WORDS) begin
      checks++;
      if (wrCyc[WORDS-1] - wrCyc[0] !== 3 * (WORDS - 1))
        $display("[TB] FAIL basic_throughput got %0d want %0d", wrCyc[WORDS-1] - wrCyc[0], 3 * (WORDS - 1));
      else passed++;
    end
    checks++; if (doneCount !== 1) $display("[TB] FAIL basic_done got %0d want 1", doneCount); else passed++;
    checks++; if (bgackN !== 1'b1 || busy !== 1'b0)
      $display("[TB] FAIL basic_release got bgack_n=%b busy=%b want 1/0", bgackN, busy); else passed++;
    checks++; if (invViol !== 0) $display("[TB] FAIL basic_invariant got %0d want 0", invViol); else passed++;
  endtask

  task automatic test_latency;
    bit to;
    staleOn = 1'b1; dropGrant = 1'b1; grantDelay = int'($urandom_range(4, 1));
    fillSource(5); clearLog();
    pulseCopy();
    waitDone(1, 400, to);
    repeat (3) tick;
    checks++; if (to) $display("[TB] FAIL latency_timeout got timeout want done"); else passed++;
    checks++; if (wrAddr.size() !== WORDS)
      $display("[TB] FAIL latency_count got %0d want %0d", wrAddr.size(), WORDS); else passed++;
    for (int k = 0; k < wrAddr.size() && k < WORDS; k++) begin
      checks++;
      if (wrAddr[k] !== k || wrData[k] !== srcMem[k])
        $display("[TB] FAIL latency_word%0d got %0d:%h want %0d:%h", k, wrAddr[k], wrData[k], k, srcMem[k]);
      else passed++;
    end
    checks++; if (doneCount !== 1 || invViol !== 0)
      $display("[TB] FAIL latency_done got done=%0d viol=%0d want 1/0", doneCount, invViol); else passed++;
    dropGrant = 1'b0;
  endtask

  task automatic test_back_to_back;
    bit to;
    staleOn = 1'b0; grantDelay = 2;
    fillSource(1); clearLog();
    pulseCopy();
    for (int p = 0; p < 3; p++) begin
      repeat (4) tick;
      checks++; if (busy !== 1'b1) $display("[TB] FAIL b2b_busy%0d got %b want 1", p, busy); else passed++;
      pulseCopy();
    end
    waitDone(2, 400, to);
    repeat (30) tick;
    checks++; if (to) $display("[TB] FAIL b2b_timeout got timeout want 2 done"); else passed++;
    checks++; if (doneCount !== 2) $display("[TB] FAIL b2b_done got %0d want 2", doneCount); else passed++;
    checks++; if (wrAddr.size() !== 2 * WORDS)
      $display("[TB] FAIL b2b_count got %0d want %0d", wrAddr.size(), 2 * WORDS); else passed++;
    for (int k = 0; k < wrAddr.size() && k < 2 * WORDS; k++) begin
      checks++;
      if (wrAddr[k] !== k % WORDS || wrData[k] !== srcMem[k % WORDS])
        $display("[TB] FAIL b2b_word%0d got %0d:%h want %0d:%h", k, wrAddr[k], wrData[k], k % WORDS, srcMem[k % WORDS]);
      else passed++;
    end
    checks++; if (busy !== 1'b0 || invViol !== 0)
      $display("[TB] FAIL b2b_idle got busy=%b viol=%0d want 0/0", busy, invViol); else passed++;
  endtask

  task automatic test_grant_hold;
    bit to;
    int holdBad = 0;
    staleOn = 1'b1; holdGrant = 1'b1;
    fillSource(2); clearLog();
    pulseCopy();
    tick;
    repeat (100) begin
      tick;
      if (brN !== 1'b0 || srcCs !== 1'b0 || dstWe !== 1'b0) holdBad++;
    end
    checks++; if (holdBad !== 0) $display("[TB] FAIL hold_bus got %0d bad cycles want 0", holdBad); else passed++;
    holdGrant = 1'b0;
    waitDone(1, 300, to);
    repeat (3) tick;
    checks++; if (to || wrAddr.size() !== WORDS)
      $display("[TB] FAIL hold_release got timeout=%b writes=%0d want 0/%0d", to, wrAddr.size(), WORDS); else passed++;
    checks++; if (wrData.size() == WORDS && wrData[WORDS-1] !== srcMem[WORDS-1])
      $display("[TB] FAIL hold_lastword got %h want %h", wrData[WORDS-1], srcMem[WORDS-1]); else passed++;
  endtask

  task automatic test_reset_abort;
    bit found = 1'b0;
    staleOn = 1'b0;
    fillSource(0); clearLog();
    pulseCopy();
    for (int i = 0; i < 200 && !found; i++) begin
      tick;
      if (srcCs === 1'b1 && srcAddr === AW'(4)) found = 1'b1;
    end
    checks++; if (!found || bgackN !== 1'b0)
      $display("[TB] FAIL abort_reach got found=%b bgack_n=%b want 1/0", found, bgackN); else passed++;
    rst_n = 1'b0;
    #1;
    checks++; if (brN !== 1'b1 || bgackN !== 1'b1)
      $display("[TB] FAIL abort_async got br_n=%b bgack_n=%b want 1/1", brN, bgackN); else passed++;
    checks++; if (busy !== 1'b0 || srcCs !== 1'b0)
      $display("[TB] FAIL abort_state got busy=%b src_cs=%b want 0/0", busy, srcCs); else passed++;
    repeat (3) tick;
    rst_n = 1'b1;
    repeat (20) tick;
    checks++; if (doneCount !== 0 || wrAddr.size() !== 4)
      $display("[TB] FAIL abort_after got done=%0d writes=%0d want 0/4", doneCount, wrAddr.size()); else passed++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL abort_idle got %b want 0", busy); else passed++;
  endtask

  task automatic test_reset_edge;
    bit to;
    bit sawBusy = 1'b0;
    fillSource(0); clearLog();
    tick; rst_n = 1'b0; objCopy = 1'b1;
    repeat (2) tick;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (busy === 1'b1) sawBusy = 1'b1;
    end
    objCopy = 1'b0;
    checks++; if (!sawBusy) $display("[TB] FAIL edge_start got busy=0 want 1"); else passed++;
    waitDone(1, 200, to);
    repeat (3) tick;
    checks++; if (to || wrAddr.size() !== WORDS || doneCount !== 1)
      $display("[TB] FAIL edge_transfer got writes=%0d done=%0d want %0d/1", wrAddr.size(), doneCount, WORDS); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latency();
    test_back_to_back();
    test_grant_hold();
    test_reset_abort();
    test_reset_edge();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/jtcop_obj_dma.md
JTCOP_OBJ_DMA -- requirements
Module: jtcop_obj_dma

Interface
REQ-001 SHALL have parameter AW, default 10: object RAM word-address width; one transfer copies 2**AW words.
REQ-002 SHALL have port clk  in  1  system clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port obj_copy  in  1  copy request from the CPU address decoder; a level that is held while /AS is low.
REQ-005 SHALL have port br_n  out  1  68000 bus request, active low.
REQ-006 SHALL have port bg_n  in  1  68000 bus grant, active low.
REQ-007 SHALL have port bgack_n  out  1  68000 bus-grant acknowledge, active low.
REQ-008 SHALL have port src_cs  out  1  object RAM read strobe.
REQ-009 SHALL have port src_addr  out  AW  object RAM word address.
REQ-010 SHALL have port src_dout  in  16  object RAM read data.
REQ-011 SHALL have port src_ok  in  1  read data valid.
REQ-012 SHALL have port dst_we  out  1  object buffer write enable.
REQ-013 SHALL have port dst_addr  out  AW  object buffer word address.
REQ-014 SHALL have port dst_din  out  16  object buffer write data.
REQ-015 SHALL have port busy  out  1  high in every state except IDLE.
REQ-016 SHALL have port done  out  1  one-clock pulse when a transfer completes.

Function
REQ-017 SHALL register obj_copy into obj_copy_l; a rising edge (obj_copy=1, obj_copy_l=0) SHALL set the pending flag pend on that clock edge.
REQ-018 SHALL define FSM states IDLE, REQ, RD, WR and DONE.
REQ-019 IDLE: if pend=1, the FSM SHALL go to REQ, clear pend, reset the word counter cnt to 0, and drive br_n=0 from the next cycle.
REQ-020 REQ: br_n SHALL stay 0 until bg_n is sampled 0; on that edge the FSM SHALL drive bgack_n=0 and br_n=1, then go to RD.
REQ-021 RD: src_cs=1 and src_addr=cnt; src_ok SHALL be ignored in the first RD cycle, which masks stale ok.
REQ-022 RD: from the second RD cycle, src_ok=1 SHALL latch src_dout into a data register and move the FSM to WR; RD SHALL have no timeout.
REQ-023 WR: dst_we=1 for exactly one clock, with dst_addr=cnt and dst_din=latched data; src_cs=0.
REQ-024 After WR, cnt SHALL increment modulo 2**AW; if cnt was 2**AW-1 the FSM SHALL go to DONE, otherwise to RD.
REQ-025 DONE: lasts one clock; done=1; bgack_n=1 from the next cycle; then the FSM SHALL go to IDLE.
REQ-026 Minimum throughput with src_ok held at 1: 3 clocks per word; a full transfer takes 3*2**AW clocks plus handshake overhead.
REQ-027 An obj_copy rising edge while busy=1 SHALL set pend; the ongoing transfer SHALL NOT restart; exactly one more transfer SHALL follow after IDLE.
REQ-028 Multiple edges during one transfer SHALL collapse to a single pending request.
REQ-029 A rising edge that coincides with pend being cleared in IDLE SHALL leave pend=1.
REQ-030 bg_n going high while bgack_n=0 SHALL have no effect; the transfer continues.
REQ-031 bgack_n SHALL be low only in the RD, WR and DONE states; br_n and bgack_n SHALL never be low at the same time.
REQ-032 When not in RD, src_cs SHALL be 0; when not in WR, dst_we SHALL be 0; src_addr and dst_addr SHALL always equal cnt.

Reset
REQ-033 rst_n=0 SHALL immediately set: state=IDLE, pend=0, cnt=0, obj_copy_l=0, data register=0, br_n=1, bgack_n=1, src_cs=0, dst_we=0, busy=0, done=0.
REQ-034 Reset asserted mid-transfer SHALL abort the transfer without completing it; done SHALL NOT pulse and the bus SHALL be released asynchronously.
REQ-035 If obj_copy is already high when rst_n is deasserted, the next clock SHALL register a rising edge, because obj_copy_l resets to 0.

Verification
REQ-036 AW=3, src_ok=1, bg_n returns 0 two clocks after br_n falls, obj_copy pulsed once -> 8 dst_we pulses at addresses 0..7 with matching data, one done pulse, bgack_n back to 1.
REQ-037 Source RAM returns a word-dependent src_ok latency of 0-5 clocks and a stale src_ok=1 in the first RD cycle -> no write uses stale data; dst data equals the source pattern.
REQ-038 obj_copy raised 3 times during one transfer -> exactly 2 transfers in total and 2 done pulses.
REQ-039 bg_n held high for 100 clocks -> br_n=0 throughout, no src_cs or dst_we activity; the transfer starts once bg_n=0.
REQ-040 rst_n pulled low while cnt=4 -> br_n and bgack_n go to 1 without waiting for clk, no done pulse; after release with obj_copy low the FSM stays in IDLE.
REQ-041 Assertion across all runs: br_n and bgack_n are never both 0, and dst_we is never high for 2 consecutive clocks.
